// File: rtl/cmd_sched_pkg.sv
// cmd_sched_pkg: shared state encoding and CAS/PRE opcodes for the DDR4 command scheduler.
// The CLOSE state only exists when CLOSED_PAGE_EN is defined.
package cmd_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT_RP,
        ACT,
        WAIT_RCD,
        CAS,
        BURST
`ifdef CLOSED_PAGE_EN
        , CLOSE
`endif
    } state_t;

    // Opcode field carried on A[16:14] for non-ACT commands
    localparam logic [2:0] OP_RD  = 3'b101;
    localparam logic [2:0] OP_WR  = 3'b100;
    localparam logic [2:0] OP_PRE = 3'b010;
    localparam int         OP_LSB = 14;

endpackage

// File: rtl/cmd_sched_bank_table.sv
// cmd_sched_bank_table: open-row table, one valid bit and one row per bank.
// Lookup is combinational from the registered table; writes land on the next clock edge.
module cmd_sched_bank_table #(
    parameter int ADDRWIDTH = 17,
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BGWIDTH-1:0]   lk_bg,
    input  logic [BAWIDTH-1:0]   lk_ba,
    output logic                 lk_valid,
    output logic [ADDRWIDTH-1:0] lk_row,
    input  logic                 wr_en,
    input  logic                 wr_set,
    input  logic [BGWIDTH-1:0]   wr_bg,
    input  logic [BAWIDTH-1:0]   wr_ba,
    input  logic [ADDRWIDTH-1:0] wr_row
);

    localparam int IDXW = BGWIDTH + BAWIDTH;
    localparam int NUM  = 1 << IDXW;

    logic [NUM-1:0]       valid_q, valid_d;
    logic [ADDRWIDTH-1:0] row_q [NUM];
    logic [ADDRWIDTH-1:0] row_d [NUM];
    logic [IDXW-1:0]      lk_idx, wr_idx;

    assign lk_idx   = {lk_bg, lk_ba};
    assign wr_idx   = {wr_bg, wr_ba};
    assign lk_valid = valid_q[lk_idx];
    assign lk_row   = row_q[lk_idx];

    // Apply a set (ACT: valid + row) or clear (PRE: drop valid) to one bank entry
    always_comb begin
        valid_d = valid_q;
        row_d   = row_q;
        if (wr_en) begin
            valid_d[wr_idx] = wr_set;
            if (wr_set) begin
                row_d[wr_idx] = wr_row;
            end
        end
    end

    // Table storage; reset forgets every open row
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < NUM; i++) begin
                row_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            row_q   <= row_d;
        end
    end

endmodule

// File: rtl/cmd_sched.sv
// cmd_sched: single-request DDR4 command scheduler with open-row tracking.
// Command bus is registered from the next state, so each command shows up in the cycle its state is current.
// Define CLOSED_PAGE_EN for closed-page policy (auto PRE after each burst, no row hits).
module cmd_sched
    import cmd_sched_pkg::*;
#(
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int BL        = 8,
    parameter int TRCD      = 4,
    parameter int TRP       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [COLWIDTH-1:0]  req_col,
    output logic                 cke,
    output logic                 cs_n,
    output logic                 act_n,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic [ADDRWIDTH-1:0] A,
    output logic                 row_hit,
    output logic                 busy
);

    localparam int CNT_MAX = (BL > TRCD) ? ((BL > TRP) ? BL : TRP) : ((TRCD > TRP) ? TRCD : TRP);
    localparam int CNTW    = $clog2(CNT_MAX + 1);

    // Counter preloads: the wait states last TRP-1 / TRCD-1 cycles, BURST lasts BL-1, CLOSE lasts TRP
    localparam logic [CNTW-1:0] RP_LOAD    = (TRP  > 1) ? CNTW'(TRP - 2)  : '0;
    localparam logic [CNTW-1:0] RCD_LOAD   = (TRCD > 1) ? CNTW'(TRCD - 2) : '0;
    localparam logic [CNTW-1:0] BURST_LOAD = CNTW'(BL - 2);
`ifdef CLOSED_PAGE_EN
    localparam logic [CNTW-1:0] CLOSE_LOAD = CNTW'(TRP - 1);
`endif

    state_t state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic                 lat_we_q,  lat_we_d;
    logic [BGWIDTH-1:0]   lat_bg_q,  lat_bg_d;
    logic [BAWIDTH-1:0]   lat_ba_q,  lat_ba_d;
    logic [ADDRWIDTH-1:0] lat_row_q, lat_row_d;
    logic [COLWIDTH-1:0]  lat_col_q, lat_col_d;

    logic                 cke_q,     cke_d;
    logic                 cs_n_q,    cs_n_d;
    logic                 act_n_q,   act_n_d;
    logic [BGWIDTH-1:0]   bg_q,      bg_d;
    logic [BAWIDTH-1:0]   ba_q,      ba_d;
    logic [ADDRWIDTH-1:0] a_q,       a_d;
    logic                 row_hit_q, row_hit_d;

    logic                 accept;
    logic                 tbl_valid;
    logic [ADDRWIDTH-1:0] tbl_row;
    logic                 page_hit;
    logic                 tbl_wr_en, tbl_wr_set;

    logic                 cur_we;
    logic [BGWIDTH-1:0]   cur_bg;
    logic [BAWIDTH-1:0]   cur_ba;
    logic [ADDRWIDTH-1:0] cur_row;
    logic [COLWIDTH-1:0]  cur_col;

    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign busy      = (state_q != IDLE);

`ifdef CLOSED_PAGE_EN
    assign page_hit = 1'b0;
`else
    assign page_hit = tbl_valid && (tbl_row == req_row);
`endif

    // On the accept cycle the command is built from the live request, afterwards from the latch
    assign cur_we  = accept ? req_we  : lat_we_q;
    assign cur_bg  = accept ? req_bg  : lat_bg_q;
    assign cur_ba  = accept ? req_ba  : lat_ba_q;
    assign cur_row = accept ? req_row : lat_row_q;
    assign cur_col = accept ? req_col : lat_col_q;

    assign lat_we_d  = cur_we;
    assign lat_bg_d  = cur_bg;
    assign lat_ba_d  = cur_ba;
    assign lat_row_d = cur_row;
    assign lat_col_d = cur_col;

    cmd_sched_bank_table #(
        .ADDRWIDTH (ADDRWIDTH),
        .BGWIDTH   (BGWIDTH),
        .BAWIDTH   (BAWIDTH)
    ) u_bank_table (
        .clk      (clk),
        .reset    (reset),
        .lk_bg    (req_bg),
        .lk_ba    (req_ba),
        .lk_valid (tbl_valid),
        .lk_row   (tbl_row),
        .wr_en    (tbl_wr_en),
        .wr_set   (tbl_wr_set),
        .wr_bg    (cur_bg),
        .wr_ba    (cur_ba),
        .wr_row   (cur_row)
    );

    // State, timing counter and latched request; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lat_we_q  <= 1'b0;
            lat_bg_q  <= '0;
            lat_ba_q  <= '0;
            lat_row_q <= '0;
            lat_col_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_we_q  <= lat_we_d;
            lat_bg_q  <= lat_bg_d;
            lat_ba_q  <= lat_ba_d;
            lat_row_q <= lat_row_d;
            lat_col_q <= lat_col_d;
        end
    end

    // Next state: hit goes straight to CAS, miss opens the row, conflict precharges first
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (page_hit) begin
                        state_d = CAS;
                    end else if (tbl_valid) begin
                        state_d = PRE;
                    end else begin
                        state_d = ACT;
                    end
                end
            end
            PRE: begin
                if (TRP > 1) begin
                    state_d = WAIT_RP;
                    cnt_d   = RP_LOAD;
                end else begin
                    state_d = ACT;
                end
            end
            WAIT_RP: begin
                if (cnt_q == '0) begin
                    state_d = ACT;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            ACT: begin
                if (TRCD > 1) begin
                    state_d = WAIT_RCD;
                    cnt_d   = RCD_LOAD;
                end else begin
                    state_d = CAS;
                end
            end
            WAIT_RCD: begin
                if (cnt_q == '0) begin
                    state_d = CAS;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            CAS: begin
                state_d = BURST;
                cnt_d   = BURST_LOAD;
            end
            BURST: begin
                if (cnt_q == '0) begin
`ifdef CLOSED_PAGE_EN
                    state_d = CLOSE;
                    cnt_d   = CLOSE_LOAD;
`else
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
`ifdef CLOSED_PAGE_EN
            CLOSE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Command for the upcoming cycle plus the matching open-row table update
    always_comb begin
        cke_d      = 1'b1;
        cs_n_d     = 1'b1;
        act_n_d    = 1'b1;
        a_d        = '0;
        bg_d       = cur_bg;
        ba_d       = cur_ba;
        row_hit_d  = accept && page_hit;
        tbl_wr_en  = 1'b0;
        tbl_wr_set = 1'b0;
        case (state_d)
            PRE: begin
                cs_n_d                = 1'b0;
                a_d[OP_LSB +: 3]      = OP_PRE;
                tbl_wr_en             = 1'b1;
            end
            ACT: begin
                cs_n_d     = 1'b0;
                act_n_d    = 1'b0;
                a_d        = cur_row;
                tbl_wr_en  = 1'b1;
                tbl_wr_set = 1'b1;
            end
            CAS: begin
                cs_n_d               = 1'b0;
                a_d[OP_LSB +: 3]     = cur_we ? OP_WR : OP_RD;
                a_d[COLWIDTH-1:0]    = cur_col;
            end
`ifdef CLOSED_PAGE_EN
            CLOSE: begin
                if (state_q != CLOSE) begin
                    cs_n_d           = 1'b0;
                    a_d[OP_LSB +: 3] = OP_PRE;
                    tbl_wr_en        = 1'b1;
                end
            end
`endif
            default: begin
                cs_n_d = 1'b1;
            end
        endcase
    end

    // Registered command bus; reset parks it with CKE low and no command
    always_ff @(posedge clk) begin
        if (reset) begin
            cke_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            act_n_q   <= 1'b1;
            bg_q      <= '0;
            ba_q      <= '0;
            a_q       <= '0;
            row_hit_q <= 1'b0;
        end else begin
            cke_q     <= cke_d;
            cs_n_q    <= cs_n_d;
            act_n_q   <= act_n_d;
            bg_q      <= bg_d;
            ba_q      <= ba_d;
            a_q       <= a_d;
            row_hit_q <= row_hit_d;
        end
    end

    assign cke     = cke_q;
    assign cs_n    = cs_n_q;
    assign act_n   = act_n_q;
    assign bg      = bg_q;
    assign ba      = ba_q;
    assign A       = a_q;
    assign row_hit = row_hit_q;

endmodule

// File: doc/cmd_sched.md
CMD_SCHED -- requirements
Module: cmd_sched

Interface
REQ-001 Parameter ADDRWIDTH, default 17, row / address-bus width.
REQ-002 Parameter COLWIDTH, default 10, column width.
REQ-003 Parameter BGWIDTH, default 2, bank-group select width.
REQ-004 Parameter BAWIDTH, default 2, bank select width.
REQ-005 Parameter BL, default 8, burst length in cycles, minimum 2.
REQ-006 Parameter TRCD, default 4, ACT-to-CAS spacing in cycles, minimum 1.
REQ-007 Parameter TRP, default 4, PRE-to-ACT spacing in cycles, minimum 1.
REQ-008 Ports: clk, in, 1, single clock, all logic on its rising edge; reset, in, 1, synchronous, active-high.
REQ-009 Ports: req_valid, in, 1, request present; req_ready, out, 1, request accepted when high with req_valid.
REQ-010 Ports: req_we, in, 1, 1=write, 0=read; req_bg, in, BGWIDTH; req_ba, in, BAWIDTH; req_row, in, ADDRWIDTH; req_col, in, COLWIDTH.
REQ-011 Ports: cke, cs_n, act_n, out, 1 each; bg, out, BGWIDTH; ba, out, BAWIDTH; A, out, ADDRWIDTH; DDR4 command bus to the CMD decoder.
REQ-012 Ports: row_hit, out, 1, one-cycle pulse when an accepted request targets the already-open row; busy, out, 1, high in every state except IDLE.

Function
REQ-013 All command outputs SHALL be registered; no combinational path from req_* to the command bus.
REQ-014 Encodings: NOP = cs_n 1; ACT = cs_n 0, act_n 0, A = row; RD/WR/PRE = cs_n 0, act_n 1, A[16:14] = 101 / 100 / 010, A[COLWIDTH-1:0] = column (RD/WR) or 0 (PRE), other A bits 0.
REQ-015 States: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS, BURST; plus CLOSE under REQ-027.
REQ-016 req_ready SHALL be 1 only in IDLE; on accept, the request fields are latched and req_* are ignored until IDLE returns.
REQ-017 The open-row table holds a valid bit and a row per bank (BANKGROUPS x BANKSPERGROUP entries).
REQ-018 Accept, bank valid and row equal: IDLE->CAS next cycle, row_hit pulses in that CAS cycle.
REQ-019 Accept, bank invalid: IDLE->ACT->WAIT_RCD (TRCD-1 cycles)->CAS; the CAS command is driven exactly TRCD cycles after the ACT command.
REQ-020 Accept, bank valid and row different: IDLE->PRE->WAIT_RP (TRP-1 cycles)->ACT, then as REQ-019; ACT is driven exactly TRP cycles after PRE.
REQ-021 PRE clears the bank valid bit; ACT sets valid and stores the row in the same cycle the command is driven.
REQ-022 CAS drives RD or WR for one cycle, then BURST drives NOP for BL-1 cycles, then IDLE; hit accept-to-accept spacing is exactly BL+1 cycles.
REQ-023 Wait states and BURST SHALL drive NOP; bg/ba hold the latched bank throughout a transaction.
REQ-024 Counters count down to 0 and never wrap; with TRCD=1 or TRP=1, the wait state is skipped.

Reset
REQ-025 While reset is high: cke 0, cs_n 1, act_n 1, bg 0, ba 0, A 0, req_ready 0, row_hit 0, busy 0, all valid bits 0, state IDLE; cke becomes 1 in the first cycle after reset deasserts.
REQ-026 Reset asserted mid-transaction SHALL abandon it with no further command driven and no request replayed.

Configuration
REQ-027 Macro CLOSED_PAGE_EN: when defined, BURST exits to CLOSE, which drives PRE to the same bank, clears its valid bit, and then waits TRP-1 cycles before IDLE; row_hit is then never asserted. When not defined, open-page policy applies and CLOSE does not exist.

Structure
REQ-028 Package cmd_sched_pkg SHALL hold the state enum and the RD/WR/PRE opcode constants for A[16:14].
REQ-029 The open-row table SHALL be the sub-module cmd_sched_bank_table, with a lookup port (bg, ba -> valid, row) and a set/clear write port.

Verification (defaults)
REQ-030 After reset, the bench issues RD bg1 ba1 row 1 col 8. Response: ACT bg1 ba1 A=1; 4 cycles later, A=17'b10100000000001000; then 7 NOP cycles; then req_ready is 1.
REQ-031 Next, the bench issues WR bg1 ba1 row 1 col 8. Response: no ACT; WR A=17'b10000000000001000 in the cycle after accept, row_hit 1; the next accept comes 9 cycles after this one.
REQ-032 Next, the bench issues RD bg1 ba1 row 5. Response: PRE A=17'b01000000000000000; 4 cycles later, ACT A=5; 4 cycles later, RD.
REQ-033 The bench asserts reset in a WAIT_RCD cycle. Response: the next cycle shows cs_n 1 and cke 0; after release, a request to the same row issues ACT (table cleared).
REQ-034 The bench holds req_valid during BURST with changing fields. Response: req_ready 0, and the latched fields are unchanged on the bus.
REQ-035 With CLOSED_PAGE_EN defined, the bench issues two RDs to the same row. Response: each RD is followed, after its burst, by a PRE; the second RD repeats ACT; row_hit stays 0.
